// File: rtl/switch_gate_pkg.sv
// Shared types and helpers for the debounced multi-switch logic gate.
// The mode encoding is fixed because it is displayed directly on the mode LEDs.
package switch_gate_pkg;

    localparam int MAX_SWITCHES = 8;

    typedef enum logic [1:0] {
        MODE_AND  = 2'd0,
        MODE_OR   = 2'd1,
        MODE_XOR  = 2'd2,
        MODE_NAND = 2'd3
    } gate_mode_t;

    // Only the low 'num' bits of ops take part in the reduction.
    function automatic logic gate_reduce(input gate_mode_t mode,
                                         input logic [MAX_SWITCHES-1:0] ops,
                                         input int num = MAX_SWITCHES);
        logic all_one;
        logic any_one;
        logic parity;
        logic result;
        all_one = 1'b1;
        any_one = 1'b0;
        parity  = 1'b0;
        for (int i = 0; i < MAX_SWITCHES; i++) begin
            if (i < num) begin
                all_one = all_one & ops[i];
                any_one = any_one | ops[i];
                parity  = parity ^ ops[i];
            end
        end
        case (mode)
            MODE_AND:  result = all_one;
            MODE_OR:   result = any_one;
            MODE_XOR:  result = parity;
            MODE_NAND: result = ~all_one;
            default:   result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// One debounce channel: 2-FF synchroniser followed by a stable-count filter.
// The state only flips after DEBOUNCE_LIMIT consecutive clocks of disagreement.
module debounce_filter #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Raw,
    output logic o_State
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             state_q, state_d;
    logic             sync;

    assign sync = sync_q[1];

    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    always_comb begin
        sync_d  = {sync_q[0], i_Raw};
        cnt_d   = cnt_q;
        state_d = state_q;
        if (sync == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            state_d = sync;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            state_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign o_State = state_q;

endmodule

// File: rtl/switch_gate_debounced.sv
// Debounced N-input gate with a button-selected operation (AND/OR/XOR/NAND).
// Channel NUM_SWITCHES is the mode button; its debounced rising edge advances the mode.
module switch_gate_debounced
    import switch_gate_pkg::*;
#(
    parameter int NUM_SWITCHES   = 4,
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_n,
    input  logic [NUM_SWITCHES-1:0] i_Switch,
    input  logic                    i_Mode_Switch,
    output logic                    o_LED_1,
    output logic [1:0]              o_Mode_LED
);

    logic [NUM_SWITCHES:0]   raw;
    logic [NUM_SWITCHES:0]   clean;
    logic [MAX_SWITCHES-1:0] ops_ext;
    logic                    mode_state;

    assign raw = {i_Mode_Switch, i_Switch};

    for (genvar g = 0; g <= NUM_SWITCHES; g++) begin : g_db
        debounce_filter #(
            .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT)
        ) u_db (
            .i_Clk   (i_Clk),
            .i_Rst_n (i_Rst_n),
            .i_Raw   (raw[g]),
            .o_State (clean[g])
        );
    end

    assign ops_ext    = MAX_SWITCHES'(clean[NUM_SWITCHES-1:0]);
    assign mode_state = clean[NUM_SWITCHES];

    gate_mode_t mode_q, mode_d;
    logic       mode_prev_q, mode_prev_d;
    logic       led_q, led_d;

    // The result register uses the pre-advance mode, so a coincident mode
    // advance reaches the LED one clock after the operand change.
    always_comb begin
        mode_prev_d = mode_state;
        mode_d      = mode_q;
        if (mode_state && !mode_prev_q) begin
            mode_d = gate_mode_t'(mode_q + 2'd1);
        end
        led_d = gate_reduce(mode_q, ops_ext, NUM_SWITCHES);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            mode_q      <= MODE_AND;
            mode_prev_q <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            mode_prev_q <= mode_prev_d;
            led_q       <= led_d;
        end
    end

    assign o_LED_1    = led_q;
    assign o_Mode_LED = mode_q;

endmodule
